// File: rtl/vldu_beat_tracker.sv
// Purpose: pairs addrgen burst descriptors with AXI R beats and emits a per-beat valid byte window.
// Latency: one cycle from an accepted R beat to beat_valid_o; full throughput with beat_ready_i high.
// Backpressure: a held beat with beat_ready_i low drops r_ready_o; beat fields stay stable until taken.
//
// Ports:
//   insn_*  : one vector load (total byte count), accepted only when idle
//   req_*   : burst descriptor (start address, AXI len) popped from the addrgen queue
//   r_*     : AXI R channel (data, last)
//   beat_*  : data to lanes plus inclusive [first,last] byte window and instruction-done flag
//   error_o : one-cycle pulse when r_last disagrees with the descriptor's beat count
module vldu_beat_tracker #(
   parameter int unsigned AxiDataWidth   = 64,
   parameter int unsigned AxiAddrWidth   = 64,
   parameter int unsigned InsnBytesWidth = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,

   input  logic                          insn_valid_i,
   input  logic [InsnBytesWidth-1:0]     insn_bytes_i,
   output logic                          insn_ready_o,

   input  logic                          req_valid_i,
   input  logic [AxiAddrWidth-1:0]       req_addr_i,
   input  logic [7:0]                    req_len_i,
   output logic                          req_ready_o,

   input  logic                          r_valid_i,
   input  logic [AxiDataWidth-1:0]       r_data_i,
   input  logic                          r_last_i,
   output logic                          r_ready_o,

   output logic                          beat_valid_o,
   input  logic                          beat_ready_i,
   output logic [AxiDataWidth-1:0]       beat_data_o,
   output logic [$clog2(AxiDataWidth/8)-1:0] beat_first_o,
   output logic [$clog2(AxiDataWidth/8)-1:0] beat_last_o,
   output logic                          beat_insn_done_o,
   output logic                          error_o
);

   localparam int unsigned NB  = AxiDataWidth / 8;
   localparam int unsigned NBW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, WAIT_REQ, STREAM, DRAIN} state_e;

   state_e                    state_q, state_d;

   logic [InsnBytesWidth-1:0] bytes_left_q;
   logic [7:0]                beats_left_q;
   logic [NBW-1:0]            offset_q;
   logic                      first_q;

   logic                      beat_valid_q;
   logic [AxiDataWidth-1:0]   beat_data_q;
   logic [NBW-1:0]            beat_first_q;
   logic [NBW-1:0]            beat_last_q;
   logic                      beat_done_q;
   logic                      error_q;

   logic                      insn_fire, req_fire, r_fire, stream_fire;
   logic [NBW-1:0]            fb;
   logic [InsnBytesWidth-1:0] avail, take;
   logic [NBW-1:0]            last_idx;
   logic                      insn_done, burst_end, last_mismatch;

   // Only the in-beat offset of the burst address matters here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr_i[AxiAddrWidth-1:NBW];

   assign insn_fire   = insn_valid_i & insn_ready_o;
   assign req_fire    = req_valid_i & req_ready_o;
   assign r_fire      = r_valid_i & r_ready_o;
   assign stream_fire = r_fire & (state_q == STREAM);

   // Byte window of the beat currently on the R channel.
   assign fb    = first_q ? offset_q : '0;
   assign avail = InsnBytesWidth'(NB) - InsnBytesWidth'(fb);
   assign take  = (bytes_left_q < avail) ? bytes_left_q : avail;
   // fb + take <= NB, so the sum modulo NB minus one is the inclusive last index
   // (take == NB only with fb == 0, where the wrap yields NB-1).
   assign last_idx  = fb + take[NBW-1:0] - NBW'(1);
   assign insn_done = (bytes_left_q == take);

   // A burst ends on r_last or once the descriptor's beats are exhausted; any
   // disagreement between the two is reported but otherwise tolerated.
   assign burst_end     = r_last_i || (beats_left_q == '0);
   assign last_mismatch = r_last_i != (beats_left_q == '0);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (insn_fire) state_d = WAIT_REQ;
         WAIT_REQ: if (req_fire)  state_d = STREAM;
         STREAM: begin
            if (r_fire) begin
               if (insn_done && burst_end) state_d = IDLE;
               else if (insn_done)         state_d = DRAIN;
               else if (burst_end)         state_d = WAIT_REQ;
            end
         end
         DRAIN:    if (r_fire && r_last_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      insn_ready_o = 1'b0;
      req_ready_o  = 1'b0;
      r_ready_o    = 1'b0;
      case (state_q)
         IDLE:          insn_ready_o = insn_valid_i;
         WAIT_REQ:      req_ready_o  = req_valid_i;
         STREAM, DRAIN: r_ready_o    = !beat_valid_q || beat_ready_i;
         default: ;
      endcase
   end

   // ---------------- Counters ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bytes_left_q <= '0;
         beats_left_q <= '0;
         offset_q     <= '0;
         first_q      <= 1'b0;
      end else begin
         if (insn_fire) bytes_left_q <= insn_bytes_i;
         else if (stream_fire) bytes_left_q <= bytes_left_q - take;

         if (req_fire) begin
            beats_left_q <= req_len_i;
            offset_q     <= req_addr_i[NBW-1:0];
            first_q      <= 1'b1;
         end else begin
            if (r_fire && (beats_left_q != '0)) beats_left_q <= beats_left_q - 8'd1;
            if (stream_fire) first_q <= 1'b0;
         end
      end
   end

   // ---------------- Output register ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_valid_q <= 1'b0;
         beat_data_q  <= '0;
         beat_first_q <= '0;
         beat_last_q  <= '0;
         beat_done_q  <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         if (stream_fire) begin
            beat_valid_q <= 1'b1;
            beat_data_q  <= r_data_i;
            beat_first_q <= fb;
            beat_last_q  <= last_idx;
            beat_done_q  <= insn_done;
         end else if (beat_ready_i) begin
            beat_valid_q <= 1'b0;
         end
         error_q <= r_fire && last_mismatch;
      end
   end

   assign beat_valid_o     = beat_valid_q;
   assign beat_data_o      = beat_data_q;
   assign beat_first_o     = beat_first_q;
   assign beat_last_o      = beat_last_q;
   assign beat_insn_done_o = beat_done_q;
   assign error_o          = error_q;

endmodule

// File: tb/tb_vldu_beat_tracker.sv
`timescale 1ns/1ps
module tb_vldu_beat_tracker;

   localparam int DW = 64;
   localparam int AW = 64;
   localparam int IW = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          insn_valid_i = 1'b0;
   logic [IW-1:0] insn_bytes_i = '0;
   logic          insn_ready_o;
   logic          req_valid_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [7:0]    req_len_i = '0;
   logic          req_ready_o;
   logic          r_valid_i = 1'b0;
   logic [DW-1:0] r_data_i = '0;
   logic          r_last_i = 1'b0;
   logic          r_ready_o;
   logic          beat_valid_o;
   logic          beat_ready_i = 1'b0;
   logic [DW-1:0] beat_data_o;
   logic [2:0]    beat_first_o;
   logic [2:0]    beat_last_o;
   logic          beat_insn_done_o;
   logic          error_o;

   vldu_beat_tracker #(.AxiDataWidth(DW), .AxiAddrWidth(AW), .InsnBytesWidth(IW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .insn_valid_i(insn_valid_i), .insn_bytes_i(insn_bytes_i), .insn_ready_o(insn_ready_o),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_ready_o(req_ready_o),
      .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_last_i(r_last_i), .r_ready_o(r_ready_o),
      .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i), .beat_data_o(beat_data_o),
      .beat_first_o(beat_first_o), .beat_last_o(beat_last_o),
      .beat_insn_done_o(beat_insn_done_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed { logic [63:0] d; logic [2:0] f; logic [2:0] l; logic dn; } beat_t;
   typedef struct packed { logic [63:0] d; logic last; } rbeat_t;
   typedef struct packed { logic [63:0] a; logic [7:0] len; } desc_t;

   // Directed vector: inputs plus expected windows, packed as one byte per beat
   // ({first,last} nibbles), beat 0 in the top byte.
   typedef struct {
      int unsigned      bytes;
      longint unsigned  a0;
      int unsigned      l0;
      longint unsigned  a1;
      int unsigned      l1;
      int unsigned      nbur;
      int unsigned      early;   // beat index of burst 0 carrying an early r_last, 255 = none
      int unsigned      nexp;
      logic [31:0]      wins;
      int unsigned      done_at;
      int unsigned      nerr;
      int unsigned      err_at;  // error expected the cycle after this R beat index
   } vec_t;

   rbeat_t      r_q[$];
   desc_t       d_q[$];
   int unsigned i_q[$];
   beat_t       got[$];
   int          rcyc[$];
   int          gcyc[$];

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          err_cnt = 0;
   int          err_cyc = 0;
   int unsigned req_acc = 0;
   bit          r_hs = 0, req_hs = 0, insn_hs = 0;
   int unsigned bp_mode = 0;        // 0: ready high, 1: random, 2: forced low
   int unsigned r_rate = 100, req_rate = 100, insn_rate = 100;

   // Input drivers: change only 1 ns after the rising edge.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_ni) begin
            insn_valid_i = 1'b0;
            req_valid_i  = 1'b0;
            r_valid_i    = 1'b0;
            r_last_i     = 1'b0;
            beat_ready_i = 1'b0;
         end else begin
            if (insn_hs) begin void'(i_q.pop_front()); insn_valid_i = 1'b0; end
            if (!insn_valid_i && i_q.size() > 0 && $urandom_range(0, 99) < insn_rate) begin
               insn_valid_i = 1'b1;
               insn_bytes_i = i_q[0];
            end
            if (req_hs) begin void'(d_q.pop_front()); req_valid_i = 1'b0; end
            if (!req_valid_i && d_q.size() > 0 && $urandom_range(0, 99) < req_rate) begin
               req_valid_i = 1'b1;
               req_addr_i  = d_q[0].a;
               req_len_i   = d_q[0].len;
            end
            if (r_hs) begin void'(r_q.pop_front()); r_valid_i = 1'b0; r_last_i = 1'b0; end
            if (!r_valid_i && r_q.size() > 0 && $urandom_range(0, 99) < r_rate) begin
               r_valid_i = 1'b1;
               r_data_i  = r_q[0].d;
               r_last_i  = r_q[0].last;
            end
            if (bp_mode == 0)      beat_ready_i = 1'b1;
            else if (bp_mode == 2) beat_ready_i = 1'b0;
            else                   beat_ready_i = ($urandom_range(0, 99) < 70);
         end
      end
   end

   // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
   initial begin
      forever begin
         @(negedge clk_i);
         cyc++;
         if (!rst_ni) begin
            r_hs = 0; req_hs = 0; insn_hs = 0;
         end else begin
            if (error_o) begin err_cnt++; err_cyc = cyc; end
            if (beat_valid_o && beat_ready_i) begin
               got.push_back({beat_data_o, beat_first_o, beat_last_o, beat_insn_done_o});
               gcyc.push_back(cyc);
            end
            r_hs    = r_valid_i && r_ready_o;
            req_hs  = req_valid_i && req_ready_o;
            insn_hs = insn_valid_i && insn_ready_o;
            if (r_hs) rcyc.push_back(cyc);
            if (req_hs) req_acc++;
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk_i); #1; end
   endtask

   task automatic clear_obs();
      got.delete(); rcyc.delete(); gcyc.delete();
      err_cnt = 0;
   endtask

   task automatic wait_idle(input int exp_beats, input int budget, input string nm);
      int c;
      c = 0;
      while (!(got.size() >= exp_beats && r_q.size() == 0 && d_q.size() == 0 && i_q.size() == 0)
             && c < budget) begin
         tick(1);
         c++;
      end
      chk({nm, " timeout"}, longint'(c >= budget), 0);
      tick(4);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      logic [63:0]     sent[$];
      logic [63:0]     data;
      logic [7:0]      w;
      desc_t           dd;
      int unsigned     len, nbt;
      int unsigned     req0;
      clear_obs();
      req0 = req_acc;
      i_q.push_back(v.bytes);
      for (int b = 0; b < int'(v.nbur); b++) begin
         dd.a   = (b == 0) ? v.a0 : v.a1;
         len    = (b == 0) ? v.l0 : v.l1;
         dd.len = 8'(len);
         d_q.push_back(dd);
         nbt = (b == 0 && v.early != 255) ? v.early + 1 : len + 1;
         for (int k = 0; k < int'(nbt); k++) begin
            data = {$urandom, $urandom};
            sent.push_back(data);
            r_q.push_back({data, (k == int'(nbt) - 1)});
         end
      end
      wait_idle(int'(v.nexp), 400, nm);
      chk({nm, " beat count"}, got.size(), v.nexp);
      for (int i = 0; i < int'(v.nexp) && i < got.size(); i++) begin
         w = v.wins[31 - 8*i -: 8];
         chk($sformatf("%s b%0d first", nm, i), got[i].f, w[7:4]);
         chk($sformatf("%s b%0d last", nm, i), got[i].l, w[3:0]);
         chk($sformatf("%s b%0d done", nm, i), got[i].dn, (i == int'(v.done_at)));
         chk($sformatf("%s b%0d data", nm, i), got[i].d, sent[i]);
      end
      if (gcyc.size() > 0 && rcyc.size() > 0)
         chk({nm, " first-beat latency"}, gcyc[0] - rcyc[0], 1);
      chk({nm, " error count"}, err_cnt, v.nerr);
      if (v.nerr > 0 && rcyc.size() > v.err_at)
         chk({nm, " error timing"}, err_cyc - rcyc[v.err_at], 1);
      chk({nm, " descriptors popped"}, req_acc - req0, v.nbur);
   endtask

   vec_t vt[8];

   initial begin
      logic [63:0] sent[$];
      logic [63:0] data;
      desc_t       dd;
      beat_t       exp_q[$];
      beat_t       e;
      int          c;
      int unsigned rem, fb, take, len, ndesc, req0;

      vt[0] = '{bytes:32, a0:'h1000, l0:3, a1:0, l1:0, nbur:1, early:255, nexp:4,
                wins:32'h07070707, done_at:3, nerr:0, err_at:0};
      vt[1] = '{bytes:20, a0:'h1003, l0:2, a1:0, l1:0, nbur:1, early:255, nexp:3,
                wins:32'h37070600, done_at:2, nerr:0, err_at:0};
      vt[2] = '{bytes:24, a0:'h0FF8, l0:0, a1:'h1000, l1:1, nbur:2, early:255, nexp:3,
                wins:32'h07070700, done_at:2, nerr:0, err_at:0};
      vt[3] = '{bytes:32, a0:'h1000, l0:3, a1:'h2000, l1:1, nbur:2, early:1, nexp:4,
                wins:32'h07070707, done_at:3, nerr:1, err_at:1};
      vt[4] = '{bytes:4, a0:'h1002, l0:2, a1:0, l1:0, nbur:1, early:255, nexp:1,
                wins:32'h25000000, done_at:0, nerr:0, err_at:0};
      vt[5] = '{bytes:6, a0:'h1002, l0:0, a1:0, l1:0, nbur:1, early:255, nexp:1,
                wins:32'h27000000, done_at:0, nerr:0, err_at:0};
      vt[6] = '{bytes:1, a0:'h1007, l0:0, a1:0, l1:0, nbur:1, early:255, nexp:1,
                wins:32'h77000000, done_at:0, nerr:0, err_at:0};
      vt[7] = '{bytes:9, a0:'h1004, l0:1, a1:0, l1:0, nbur:1, early:255, nexp:2,
                wins:32'h47040000, done_at:1, nerr:0, err_at:0};

      // ---- reset state ----
      rst_ni = 1'b0;
      tick(3);
      chk("reset beat_valid", beat_valid_o, 0);
      chk("reset beat_data", beat_data_o, 0);
      chk("reset beat_first", beat_first_o, 0);
      chk("reset beat_last", beat_last_o, 0);
      chk("reset insn_done", beat_insn_done_o, 0);
      chk("reset error", error_o, 0);
      chk("reset r_ready", r_ready_o, 0);
      chk("reset req_ready", req_ready_o, 0);
      chk("reset insn_ready", insn_ready_o, 0);
      rst_ni = 1'b1;
      tick(2);

      // ---- directed table ----
      for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // ---- backpressure: beat_ready low for 5 cycles mid-burst ----
      clear_obs();
      sent.delete();
      i_q.push_back(32);
      dd.a = 64'h3000; dd.len = 8'd3;
      d_q.push_back(dd);
      for (int k = 0; k < 4; k++) begin
         data = {$urandom, $urandom};
         sent.push_back(data);
         r_q.push_back({data, (k == 3)});
      end
      c = 0;
      while (got.size() < 2 && c < 200) begin tick(1); c++; end
      chk("bp reach mid-burst timeout", longint'(c >= 200), 0);
      bp_mode = 2;
      @(posedge clk_i);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk($sformatf("bp c%0d r_ready", i), r_ready_o, 0);
         chk($sformatf("bp c%0d beat_valid", i), beat_valid_o, 1);
         if (got.size() < 4) begin
            chk($sformatf("bp c%0d data", i), beat_data_o, sent[got.size()]);
            chk($sformatf("bp c%0d window", i), {beat_first_o, beat_last_o}, 6'o07);
            chk($sformatf("bp c%0d done", i), beat_insn_done_o, (got.size() == 3));
         end
      end
      bp_mode = 0;
      wait_idle(4, 200, "bp");
      chk("bp beat count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         chk($sformatf("bp b%0d data", i), got[i].d, sent[i]);
         chk($sformatf("bp b%0d done", i), got[i].dn, (i == 3));
      end

      // ---- reset in the middle of STREAM ----
      clear_obs();
      i_q.push_back(32);
      dd.a = 64'h4000; dd.len = 8'd3;
      d_q.push_back(dd);
      for (int k = 0; k < 2; k++) r_q.push_back({{$urandom, $urandom}, 1'b0});
      c = 0;
      while (got.size() < 2 && c < 200) begin tick(1); c++; end
      chk("midrst reach timeout", longint'(c >= 200), 0);
      tick(2);
      chk("midrst r_ready before reset", r_ready_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("midrst beat_valid", beat_valid_o, 0);
      chk("midrst beat_data", beat_data_o, 0);
      chk("midrst window", {beat_first_o, beat_last_o}, 0);
      chk("midrst insn_done", beat_insn_done_o, 0);
      chk("midrst error", error_o, 0);
      chk("midrst r_ready", r_ready_o, 0);
      chk("midrst req_ready", req_ready_o, 0);
      chk("midrst insn_ready", insn_ready_o, 0);
      tick(3);
      r_q.delete(); d_q.delete(); i_q.delete();
      rst_ni = 1'b1;
      tick(2);
      run_vec(vt[1], "post-reset");

      // ---- randomized traffic against a reference model ----
      clear_obs();
      req0  = req_acc;
      ndesc = 0;
      bp_mode = 1; r_rate = 70; req_rate = 60; insn_rate = 50;
      for (int n = 0; n < 40; n++) begin
         rem = $urandom_range(1, 64);
         i_q.push_back(rem);
         while (rem > 0) begin
            dd.a   = {$urandom, $urandom};
            len    = $urandom_range(0, 3);
            dd.len = 8'(len);
            d_q.push_back(dd);
            ndesc++;
            for (int k = 0; k <= int'(len); k++) begin
               data = {$urandom, $urandom};
               if (rem > 0) begin
                  fb   = (k == 0) ? int'(dd.a % 8) : 0;
                  take = (8 - fb < rem) ? 8 - fb : rem;
                  e.d  = data;
                  e.f  = 3'(fb);
                  e.l  = 3'(fb + take - 1);
                  e.dn = (rem == take);
                  exp_q.push_back(e);
                  rem -= take;
               end
               r_q.push_back({data, (k == int'(len))});
            end
         end
      end
      wait_idle(exp_q.size(), 20000, "rand");
      chk("rand beat count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         chk($sformatf("rand b%0d data", i), got[i].d, exp_q[i].d);
         chk($sformatf("rand b%0d first/last/done", i),
             {got[i].f, got[i].l, got[i].dn}, {exp_q[i].f, exp_q[i].l, exp_q[i].dn});
      end
      chk("rand error count", err_cnt, 0);
      chk("rand descriptors popped", req_acc - req0, ndesc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vldu_beat_tracker.md
Name: vldu_beat_tracker

Overview:
- Load-side consumer of the address generator's request queue. It pairs each queued AXI burst descriptor with the incoming AXI R beats.
- For every beat it computes the valid byte window inside the beat, then forwards the data and window to the lane write-back logic.
- It tracks the remaining bytes of the current vector load, flags instruction completion, and detects R-channel burst-length mismatches.

Parameters:
- AxiDataWidth, 64, R data width in bits. NB = AxiDataWidth/8 bytes per beat; power of two, at least 8.
- AxiAddrWidth, 64, address width of burst descriptors.
- InsnBytesWidth, 32, width of the per-instruction byte counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- insn_valid_i  in  1  new vector load available
- insn_bytes_i  in  InsnBytesWidth  total bytes to load (vl << vsew); 0 is illegal
- insn_ready_o  out  1  instruction accepted
- req_valid_i  in  1  burst descriptor available from addrgen queue
- req_addr_i  in  AxiAddrWidth  burst start address
- req_len_i  in  8  AXI len (beats-1)
- req_ready_o  out  1  pops the addrgen queue
- r_valid_i  in  1  AXI R valid
- r_data_i  in  AxiDataWidth  AXI R data
- r_last_i  in  1  AXI R last
- r_ready_o  out  1  AXI R ready
- beat_valid_o  out  1  beat to lanes valid
- beat_ready_i  in  1  lanes accept beat
- beat_data_o  out  AxiDataWidth  beat data, unmodified
- beat_first_o  out  $clog2(NB)  first valid byte index
- beat_last_o  out  $clog2(NB)  last valid byte index, inclusive
- beat_insn_done_o  out  1  this beat completes the instruction
- error_o  out  1  one-cycle pulse on r_last mismatch

Behaviour:
- Reset: FSM to IDLE. All counters 0. beat_valid_o=0, beat_data_o=0, beat_first_o=0, beat_last_o=0, beat_insn_done_o=0, error_o=0. insn_ready_o, req_ready_o and r_ready_o are 0 in the reset state. A reset mid-operation discards all in-flight state; no partial beat is emitted afterwards.
- FSM states:
  - IDLE: insn_ready_o=insn_valid_i. On the handshake, bytes_left_q <= insn_bytes_i and go to WAIT_REQ.
  - WAIT_REQ: req_ready_o=req_valid_i. On the handshake, latch offset_q <= req_addr_i[$clog2(NB)-1:0], beats_left_q <= req_len_i, first_q <= 1, and go to STREAM.
  - STREAM: consume R beats as described below.
  - DRAIN: consume remaining R beats of the current burst without forwarding them.
- Output register is a single stage with r_ready_o = (state==STREAM || state==DRAIN) && (!beat_valid_o || beat_ready_i). It gives exactly 1 cycle of R-to-beat latency and full throughput when beat_ready_i is held high. Output fields stay stable while beat_valid_o=1 and beat_ready_i=0.
- Per accepted beat in STREAM:
  - fb = first_q ? offset_q : 0
  - avail = NB - fb
  - take = min(avail, bytes_left_q)
  - beat_first_o = fb; beat_last_o = fb + take - 1
  - bytes_left_q -= take; first_q <= 0; beats_left_q -= 1, saturating at 0
  - beat_insn_done_o = (bytes_left_q == take)
- Transitions after a beat:
  - Instruction done and beat was the last of its burst: go to IDLE.
  - Instruction done with more beats outstanding: go to DRAIN.
  - Last beat of the burst but instruction not done: go to WAIT_REQ for the next descriptor.
- Last-beat mismatch: r_last_i=1 while beats_left_q!=0, or r_last_i=0 while beats_left_q==0, pulses error_o in the following cycle. The beat is still processed normally. The burst is treated as ended when r_last_i=1, or when beats_left_q==0 (further beats then count against the next descriptor).
- DRAIN: beats are accepted and not forwarded. Leave to IDLE on r_last_i.
- A new instruction is accepted only in IDLE, never overlapped. The insn_ready_o handshake in IDLE can coincide with the final beat leaving the output register.
- All arithmetic is unsigned. take never exceeds NB. bytes_left_q never underflows.

Test Plan (NB=8):
- Aligned unit load: insn_bytes=32, req addr=0x1000, len=3, 4 R beats → 4 beats with first=0, last=7; done only on beat 4; FSM returns to IDLE.
- Misaligned start: insn_bytes=20, addr=0x1003, len=2 → windows (3,7), (0,7), (0,6); done on beat 3; no error.
- Multi-burst across 4 KiB page: insn_bytes=24, bursts {addr=0x0FF8, len=0} then {0x1000, len=1} → windows (0,7), (0,7), (0,7); req_ready_o pulses twice; done on beat 3.
- Backpressure: beat_ready_i low for 5 cycles mid-burst → r_ready_o=0 for those cycles; beat fields stable; no beat lost or duplicated.
- rlast mismatch: len=3 but r_last_i asserted on beat 2 → error_o pulses once, the cycle after that beat; FSM moves to WAIT_REQ.
- Reset mid-STREAM after 2 of 4 beats → all outputs 0; the next instruction is tracked correctly from IDLE.
